frame_aligner: RTL and testbench

FRAME_ALIGNER -- requirements
Module: frame_aligner

---
 rtl/frame_aligner.sv | 153 +++++++++++++++
 tb/tb_frame_aligner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_aligner.sv
// Byte-stream frame aligner: hunts for a two-byte header in a 12-byte cadence,
// locks after LOCK_FRAMES legal frames and unlocks after UNLOCK_FRAMES bad headers.
module frame_aligner #(
    parameter logic [15:0] HDR1          = 16'hAFAA,
    parameter logic [15:0] HDR2          = 16'hBA55,
    parameter int          PAYLOAD_LEN   = 10,
    parameter int          LOCK_FRAMES   = 3,
    parameter int          UNLOCK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    output logic [3:0] fr_byte_position,
    output logic       frame_detect
);

    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam int UW = $clog2(UNLOCK_FRAMES + 1);

    localparam logic [7:0]    LSB1       = HDR1[7:0];
    localparam logic [7:0]    MSB1       = HDR1[15:8];
    localparam logic [7:0]    LSB2       = HDR2[7:0];
    localparam logic [7:0]    MSB2       = HDR2[15:8];
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FRAMES);
    localparam logic [UW-1:0] UNLOCK_MAX = UW'(UNLOCK_FRAMES);
    localparam logic [3:0]    LAST_POS   = 4'(PAYLOAD_LEN);

    // state_q names the role of the byte currently on rx_data
    typedef enum logic [1:0] {
        SEARCH,
        HDR_MSB,
        PAYLOAD,
        HDR_LSB
    } state_t;

    state_t        state_q, state_d;
    logic          type_q, type_d;
    logic          bad_q, bad_d;
    logic [LW-1:0] legal_cnt_q, legal_cnt_d;
    logic [UW-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [3:0]    pos_d;
    logic          det_d;

    logic          is_lsb;
    logic          lsb_type;
    logic [7:0]    exp_msb;
    logic          msb_ok;
    logic [LW-1:0] legal_inc;
    logic [UW-1:0] illegal_inc;
    logic [3:0]    pos_inc;

    assign is_lsb      = (rx_data == LSB1) || (rx_data == LSB2);
    assign lsb_type    = (rx_data == LSB2);
    assign exp_msb     = type_q ? MSB2 : MSB1;
    assign msb_ok      = !bad_q && (rx_data == exp_msb);
    assign legal_inc   = (legal_cnt_q == LOCK_MAX) ? legal_cnt_q : legal_cnt_q + LW'(1);
    assign illegal_inc = (illegal_cnt_q == UNLOCK_MAX) ? illegal_cnt_q : illegal_cnt_q + UW'(1);
    assign pos_inc     = fr_byte_position + 4'd1;

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        bad_d         = bad_q;
        legal_cnt_d   = legal_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        pos_d         = '0;
        det_d         = frame_detect;

        unique case (state_q)
            SEARCH: begin
                if (is_lsb) begin
                    state_d = HDR_MSB;
                    type_d  = lsb_type;
                    bad_d   = 1'b0;
                end
            end

            HDR_LSB: begin
                if (is_lsb) begin
                    state_d = HDR_MSB;
                    type_d  = lsb_type;
                    bad_d   = 1'b0;
                end else if (frame_detect) begin
                    // locked: hold cadence, the MSB slot is judged illegal regardless
                    state_d = HDR_MSB;
                    bad_d   = 1'b1;
                end else begin
                    state_d     = SEARCH;
                    legal_cnt_d = '0;
                end
            end

            HDR_MSB: begin
                if (msb_ok) begin
                    state_d       = PAYLOAD;
                    legal_cnt_d   = legal_inc;
                    illegal_cnt_d = '0;
                    if (legal_inc == LOCK_MAX)
                        det_d = 1'b1;
                end else if (frame_detect) begin
                    if (illegal_inc == UNLOCK_MAX) begin
                        state_d       = SEARCH;
                        det_d         = 1'b0;
                        legal_cnt_d   = '0;
                        illegal_cnt_d = '0;
                    end else begin
                        state_d       = PAYLOAD;
                        illegal_cnt_d = illegal_inc;
                    end
                end else begin
                    legal_cnt_d = '0;
                    // a mismatching byte can itself start a new header
                    if (is_lsb) begin
                        state_d = HDR_MSB;
                        type_d  = lsb_type;
                        bad_d   = 1'b0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end

            PAYLOAD: begin
                pos_d = pos_inc;
                if (pos_inc == LAST_POS)
                    state_d = HDR_LSB;
            end

            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= SEARCH;
            type_q           <= 1'b0;
            bad_q            <= 1'b0;
            legal_cnt_q      <= '0;
            illegal_cnt_q    <= '0;
            fr_byte_position <= '0;
            frame_detect     <= 1'b0;
        end else begin
            state_q          <= state_d;
            type_q           <= type_d;
            bad_q            <= bad_d;
            legal_cnt_q      <= legal_cnt_d;
            illegal_cnt_q    <= illegal_cnt_d;
            fr_byte_position <= pos_d;
            frame_detect     <= det_d;
        end
    end

endmodule

// File: tb/tb_frame_aligner.sv
// Directed bench for frame_aligner: lock, noise, unlock, hold, broken run, reset.
module tb_frame_aligner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [3:0] fr_byte_position;
    logic       frame_detect;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] vb[$];
    logic [3:0] vp[$];
    logic       vd[$];

    frame_aligner dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .fr_byte_position (fr_byte_position),
        .frame_detect     (frame_detect)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] b);
        rx_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(8'h00);
        step(8'h00);
        reset = 1'b0;
        vb.delete();
        vp.delete();
        vd.delete();
    endtask

    task automatic add(input logic [7:0] b, input logic [3:0] p, input logic d);
        vb.push_back(b);
        vp.push_back(p);
        vd.push_back(d);
    endtask

    // aligned=1: payload bytes expected at positions 1..10, else 0 (sliding in SEARCH)
    task automatic add_frame(input logic [7:0] lsb, input logic [7:0] msb,
                             input logic d_lsb, input logic d_msb, input logic aligned);
        add(lsb, 4'd0, d_lsb);
        add(msb, 4'd0, d_msb);
        for (int i = 0; i < 10; i++)
            add(8'h10 + 8'(i), aligned ? 4'(i + 1) : 4'd0, d_msb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(8'hAA);
        vectors++;
        if (fr_byte_position !== 4'd0 || frame_detect !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got pos=%0d det=%0b, want pos=0 det=0", fr_byte_position, frame_detect);
        end
        step(8'hAF);
        vectors++;
        if (fr_byte_position !== 4'd0 || frame_detect !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got pos=%0d det=%0b, want pos=0 det=0", fr_byte_position, frame_detect);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL lock byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    task automatic test_noise_mixed();
        logic [7:0] noise [10] = '{8'h00, 8'h13, 8'hAF, 8'hBA, 8'h7E, 8'hAA, 8'h3C, 8'hFF, 8'h5A, 8'h01};
        do_reset();
        foreach (noise[i]) add(noise[i], 4'd0, 1'b0);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'h55, 8'hBA, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL noise byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    task automatic test_unlock();
        do_reset();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL unlock byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'h55, 8'hBA, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        add_frame(8'hAA, 8'hBA, 1'b1, 1'b1, 1'b1);
        add_frame(8'h12, 8'hAF, 1'b1, 1'b1, 1'b1);
        add_frame(8'h55, 8'hBA, 1'b1, 1'b1, 1'b1);
        add_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        add_frame(8'h55, 8'hAF, 1'b1, 1'b1, 1'b1);
        add_frame(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL hold byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    task automatic test_broken_run();
        do_reset();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'h55, 8'hBA, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hBA, 1'b0, 1'b0, 1'b0);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL broken byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        add(8'hAA, 4'd0, 1'b1);
        add(8'hAF, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) add(8'h20, 4'(i + 1), 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL premid byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
        reset = 1'b1;
        step(8'h21);
        reset = 1'b0;
        vectors++;
        if (fr_byte_position !== 4'd0 || frame_detect !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got pos=%0d det=%0b, want pos=0 det=0", fr_byte_position, frame_detect);
        end
        vb.delete();
        vp.delete();
        vd.delete();
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b0, 1'b1);
        add_frame(8'hAA, 8'hAF, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < vb.size(); i++) begin
            step(vb[i]);
            vectors++;
            if (fr_byte_position !== vp[i] || frame_detect !== vd[i]) begin
                miscompares++;
                $display("FAIL relock byte %0d: got pos=%0d det=%0b, want pos=%0d det=%0b",
                         i, fr_byte_position, frame_detect, vp[i], vd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_noise_mixed();
        test_unlock();
        test_hold();
        test_broken_run();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
